i2s_play_tx: RTL

//   CPU-to-codec playback path: buffers 32-bit stereo words from a Xillybus write stream and

---
 rtl/i2s_play_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/i2s_play_tx.sv
// i2s_play_tx: buffers 32-bit stereo words from a Xillybus write stream and
// serialises them as I2S (MSB first, one BCLK delay) onto audio_dac.
// The codec is clock master; BCLK and DAC LRCLK are sampled in bus_clk.
module i2s_play_tx #(
    parameter int unsigned FIFO_AW = 9,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               bus_clk,
    input  logic               srst,
    input  logic               enable,
    input  logic               user_w_play_wren,
    input  logic [31:0]        user_w_play_data,
    input  logic               user_w_play_open,
    output logic               user_w_play_full,
    input  logic               audio_bclk,
    input  logic               audio_dac_lrclk,
    output logic               audio_dac,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [CNT_W-1:0]   underrun_count
);

    localparam int unsigned        DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};

    // S_RUN: shifting out the current sample (zeros once it is exhausted).
    // S_LOAD: a slot boundary was seen; the next fall_ev loads a new sample.
    typedef enum logic {
        S_RUN,
        S_LOAD
    } ser_state_t;

    ser_state_t           state, state_n;

    logic [31:0]          mem [0:DEPTH-1];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     level;
    logic [31:0]          rd_data;
    logic                 wr_en, pop, underrun_inc;

    logic                 bclk_meta, bclk_sync, bclk_prev;
    logic                 lr_meta, lr_sync;
    logic                 lr_last, lr_valid;
    logic                 fall_ev, lr_now, slot_start;

    logic [15:0]          shift_reg, held_right, load_word;

    assign fall_ev    = bclk_prev & ~bclk_sync;
    assign lr_now     = lr_sync;
    // lr_last is meaningless until one fall_ev has been seen after reset
    assign slot_start = fall_ev && lr_valid && (lr_now != lr_last);

    assign user_w_play_full = (level == FULL_LEVEL);
    assign fifo_level       = level;
    assign rd_data          = mem[rd_ptr];
    assign wr_en            = user_w_play_wren && user_w_play_open && !user_w_play_full;

    // Sample the MSB straight off the shifter; zeros shifted in give the idle tail
    assign audio_dac = shift_reg[15];

    // Two-flop synchronisers plus BCLK history for falling-edge detection
    always_ff @(posedge bus_clk) begin
        if (srst) begin
            bclk_meta <= 1'b0;
            bclk_sync <= 1'b0;
            bclk_prev <= 1'b0;
            lr_meta   <= 1'b0;
            lr_sync   <= 1'b0;
        end else begin
            bclk_meta <= audio_bclk;
            bclk_sync <= bclk_meta;
            bclk_prev <= bclk_sync;
            lr_meta   <= audio_dac_lrclk;
            lr_sync   <= lr_meta;
        end
    end

    // Serialiser state register
    always_ff @(posedge bus_clk) begin
        if (srst) state <= S_RUN;
        else      state <= state_n;
    end

    // Next state, FIFO pop request and underrun detection
    always_comb begin
        state_n      = state;
        pop          = 1'b0;
        underrun_inc = 1'b0;
        if (fall_ev) begin
            if (slot_start) begin
                state_n = S_LOAD;
            end else begin
                case (state)
                    S_LOAD: begin
                        state_n = S_RUN;
                        if (!lr_now && enable) begin
                            if (level != '0) pop          = 1'b1;
                            else             underrun_inc = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sample chosen at load time: right slot replays the held half-word
    always_comb begin
        load_word = '0;
        if (lr_now)   load_word = held_right;
        else if (pop) load_word = rd_data[15:0];
    end

    // Shifter, held right sample and LRCLK history, all advanced on fall_ev only
    always_ff @(posedge bus_clk) begin
        if (srst) begin
            shift_reg  <= '0;
            held_right <= '0;
            lr_last    <= 1'b0;
            lr_valid   <= 1'b0;
        end else if (fall_ev) begin
            lr_last  <= lr_now;
            lr_valid <= 1'b1;
            if (slot_start) begin
                shift_reg <= '0;
            end else if (state == S_LOAD) begin
                shift_reg <= load_word;
                if (!lr_now) held_right <= pop ? rd_data[31:16] : '0;
            end else begin
                shift_reg <= {shift_reg[14:0], 1'b0};
            end
        end
    end

    // FIFO storage; pointers are cleared on flush so stale entries are harmless
    always_ff @(posedge bus_clk) begin
        if (wr_en) mem[wr_ptr] <= user_w_play_data;
    end

    // FIFO pointers and level; flush clears only the FIFO
    always_ff @(posedge bus_clk) begin
        if (srst || !user_w_play_open) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + (FIFO_AW+1)'(1);
                2'b01:   level <= level - (FIFO_AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Saturating count of left slots played from an empty FIFO while enabled
    always_ff @(posedge bus_clk) begin
        if (srst)
            underrun_count <= '0;
        else if (underrun_inc && (underrun_count != '1))
            underrun_count <= underrun_count + CNT_W'(1);
    end

endmodule
